// File: rtl/sdpix_unpack.sv
// SD word stream to RGB332 pixel stream: FIFO-buffered 64-bit words, raster position and markers.
// Define SDPIX_UNPACK_LSB_FIRST_EN to emit the least significant byte of each word first.
module sdpix_unpack #(
    parameter int unsigned H_PIX      = 640,
    parameter int unsigned V_PIX      = 480,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        WR,
    input  logic [63:0] DATA,
    input  logic        PIX_RDY,
    output logic        PIX_VLD,
    output logic [7:0]  PIX,
    output logic [9:0]  PIX_X,
    output logic [9:0]  PIX_Y,
    output logic        SOF,
    output logic        EOL,
    output logic        FRM_END,
    output logic        FULL,
    output logic        OVF
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [9:0]  X_LAST   = 10'(H_PIX - 1);
    localparam logic [9:0]  Y_LAST   = 10'(V_PIX - 1);

    typedef enum logic {StIdle, StRun} state_t;
    state_t state_q, state_d;

    logic [63:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q;
    logic [63:0]   word_q, word_d;
    logic [2:0]    idx_q, idx_d;
    logic [9:0]    x_q, y_q;
    logic          frm_end_q, ovf_q;
    logic          push, pop, xfer, empty, full, last_x, last_y;
    logic [5:0]    shift;

    assign full   = (count_q == FULL_CNT);
    assign empty  = (count_q == '0);
    assign push   = WR && !full;
    assign xfer   = (state_q == StRun) && PIX_RDY;
    assign last_x = (x_q == X_LAST);
    assign last_y = (y_q == Y_LAST);

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    word_d  = mem_q[rptr_q];
                    idx_d   = 3'd0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (xfer) begin
                    if (idx_q != 3'd7) begin
                        idx_d = idx_q + 3'd1;
                    end else if (!empty) begin
                        // Reload without a bubble when the next word is already waiting.
                        pop    = 1'b1;
                        word_d = mem_q[rptr_q];
                        idx_d  = 3'd0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            if (push && !pop) begin
                count_q <= count_q + (AW + 1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (AW + 1)'(1);
            end
            if (WR && full) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem_q[wptr_q] <= DATA;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= StIdle;
            word_q    <= '0;
            idx_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            frm_end_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            idx_q     <= idx_d;
            frm_end_q <= xfer && last_x && last_y;
            if (xfer) begin
                if (last_x) begin
                    x_q <= '0;
                    y_q <= last_y ? 10'd0 : y_q + 10'd1;
                end else begin
                    x_q <= x_q + 10'd1;
                end
            end
        end
    end

`ifdef SDPIX_UNPACK_LSB_FIRST_EN
    assign shift = {idx_q, 3'b000};
`else
    assign shift = {~idx_q, 3'b000};
`endif

    assign PIX_VLD = (state_q == StRun);
    assign PIX     = PIX_VLD ? word_q[shift +: 8] : 8'd0;
    assign PIX_X   = x_q;
    assign PIX_Y   = y_q;
    assign SOF     = PIX_VLD && (x_q == 10'd0) && (y_q == 10'd0);
    assign EOL     = PIX_VLD && last_x;
    assign FRM_END = frm_end_q;
    assign FULL    = full;
    assign OVF     = ovf_q;

endmodule

// File: tb/tb_sdpix_unpack.sv
// Self-checking bench for sdpix_unpack: scoreboard of expected pixels plus per-scenario timing checks.
// Honours SDPIX_UNPACK_LSB_FIRST_EN for the expected byte order.
module tb_sdpix_unpack;
    localparam int H = 8;
    localparam int V = 2;
    localparam int D = 4;

    logic        clk, rst, wr, pix_rdy;
    logic [63:0] data;
    logic        pix_vld, sof, eol, frm_end, full, ovf;
    logic [7:0]  pix;
    logic [9:0]  pix_x, pix_y;

    typedef struct packed {
        logic [7:0] pix;
        logic [9:0] x;
        logic [9:0] y;
        logic       sof;
        logic       eol;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total, bad, sb_total, sb_bad, exp_x, exp_y;
    logic frm_pend;

    sdpix_unpack #(.H_PIX(H), .V_PIX(V), .FIFO_DEPTH(D)) dut (
        .CLK(clk), .RST(rst), .WR(wr), .DATA(data), .PIX_RDY(pix_rdy),
        .PIX_VLD(pix_vld), .PIX(pix), .PIX_X(pix_x), .PIX_Y(pix_y),
        .SOF(sof), .EOL(eol), .FRM_END(frm_end), .FULL(full), .OVF(ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard: every transfer must match the oldest expected pixel.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            frm_pend = 1'b0;
        end else begin
            sb_total++;
            if (frm_end !== frm_pend) begin
                sb_bad++;
                $display("FAIL frm_end at %0t: got %b want %b", $time, frm_end, frm_pend);
            end
            frm_pend = 1'b0;
            if (pix_vld && pix_rdy) begin
                sb_total++;
                if (sb.size() == 0) begin
                    sb_bad++;
                    $display("FAIL pixel_extra at %0t: got pix=%h x=%0d y=%0d want none",
                             $time, pix, pix_x, pix_y);
                end else begin
                    e = sb.pop_front();
                    if ({pix, pix_x, pix_y, sof, eol} !== e) begin
                        sb_bad++;
                        $display("FAIL pixel at %0t: got pix=%h x=%0d y=%0d sof=%b eol=%b want pix=%h x=%0d y=%0d sof=%b eol=%b",
                                 $time, pix, pix_x, pix_y, sof, eol, e.pix, e.x, e.y, e.sof, e.eol);
                    end
                    frm_pend = (e.x == 10'(H - 1)) && (e.y == 10'(V - 1));
                end
            end
        end
    end

    function automatic logic [7:0] exp_byte(input logic [63:0] w, input int i);
`ifdef SDPIX_UNPACK_LSB_FIRST_EN
        return w[8*i +: 8];
`else
        return w[63-8*i -: 8];
`endif
    endfunction

    task automatic put_word(input logic [63:0] w, input bit keep);
        exp_t n;
        wr   = 1'b1;
        data = w;
        if (keep) begin
            for (int i = 0; i < 8; i++) begin
                n.pix = exp_byte(w, i);
                n.x   = 10'(exp_x);
                n.y   = 10'(exp_y);
                n.sof = (exp_x == 0) && (exp_y == 0);
                n.eol = (exp_x == H - 1);
                sb.push_back(n);
                exp_x++;
                if (exp_x == H) begin
                    exp_x = 0;
                    exp_y = (exp_y == V - 1) ? 0 : exp_y + 1;
                end
            end
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        wr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        exp_x = 0;
        exp_y = 0;
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles && (sb.size() != 0 || pix_vld); i++) @(negedge clk);
        total++;
        if (sb.size() != 0 || pix_vld) begin
            bad++;
            $display("FAIL drain: got %0d pixels pending want 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst     = 1'b1;
        wr      = 1'b0;
        pix_rdy = 1'b1;
        data    = '1;
        repeat (2) @(posedge clk);
        wr = 1'b1;
        @(negedge clk);
        total++;
        if ({pix_vld, pix, pix_x, pix_y, sof, eol, frm_end, full, ovf} !== 37'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0",
                     {pix_vld, pix, pix_x, pix_y, sof, eol, frm_end, full, ovf});
        end
        @(posedge clk);
        #1;
        wr    = 1'b0;
        rst   = 1'b0;
        exp_x = 0;
        exp_y = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({pix_vld, full} !== 2'b00) begin
            bad++;
            $display("FAIL reset_no_push: got vld,full=%b want 00", {pix_vld, full});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency;
        logic [63:0] w;
        w = 64'h0011223344556677;
        do_reset();
        pix_rdy = 1'b1;
        for (int c = 0; c < 12; c++) begin
            wr = 1'b0;
            if (c == 0) put_word(w, 1'b1);
            @(negedge clk);
            if (c == 1) begin
                total++;
                if (pix_vld !== 1'b0) begin
                    bad++;
                    $display("FAIL latency_early: got vld=%b want 0", pix_vld);
                end
            end
            if (c == 2) begin
                total++;
                if ({pix_vld, pix, sof} !== {1'b1, exp_byte(w, 0), 1'b1}) begin
                    bad++;
                    $display("FAIL latency_first: got vld=%b pix=%h sof=%b want 1 %h 1",
                             pix_vld, pix, sof, exp_byte(w, 0));
                end
            end
            if (c == 10) begin
                total++;
                if (pix_vld !== 1'b0) begin
                    bad++;
                    $display("FAIL latency_end: got vld=%b want 0", pix_vld);
                end
            end
            @(posedge clk);
            #1;
        end
        wait_drain(20);
    endtask

    task automatic test_back_to_back;
        int run, best, nvld;
        run  = 0;
        best = 0;
        nvld = 0;
        do_reset();
        pix_rdy = 1'b1;
        for (int c = 0; c < 30; c++) begin
            wr = 1'b0;
            if (c == 0) put_word(64'hA0A1A2A3A4A5A6A7, 1'b1);
            if (c == 8) put_word(64'hB0B1B2B3B4B5B6B7, 1'b1);
            @(negedge clk);
            if (pix_vld) begin
                run++;
                nvld++;
            end else begin
                if (run > best) best = run;
                run = 0;
            end
            @(posedge clk);
            #1;
        end
        if (run > best) best = run;
        total++;
        if (best != 16 || nvld != 16) begin
            bad++;
            $display("FAIL back_to_back: got run=%0d valid=%0d want 16 16", best, nvld);
        end
        wait_drain(20);
    endtask

    task automatic test_backpressure;
        logic [63:0] w;
        w = 64'hC1C2C3C4C5C6C7C8;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            wr      = 1'b0;
            pix_rdy = !(c >= 5 && c < 10);
            if (c == 0) put_word(w, 1'b1);
            @(negedge clk);
            if (c >= 5 && c < 10) begin
                total++;
                if ({pix_vld, pix, pix_x} !== {1'b1, exp_byte(w, 3), 10'd3}) begin
                    bad++;
                    $display("FAIL backpressure_hold c=%0d: got vld=%b pix=%h x=%0d want 1 %h 3",
                             c, pix_vld, pix, pix_x, exp_byte(w, 3));
                end
            end
            @(posedge clk);
            #1;
        end
        pix_rdy = 1'b1;
        wait_drain(20);
    endtask

    task automatic test_overflow;
        do_reset();
        for (int c = 0; c < 60; c++) begin
            wr      = 1'b0;
            pix_rdy = (c >= 7);
            if (c < D + 2) put_word({$urandom, $urandom}, c < D + 1);
            @(negedge clk);
            if (c == 4 || c == 5 || c == 6) begin
                total++;
                if (full !== (c != 4)) begin
                    bad++;
                    $display("FAIL full c=%0d: got %b want %b", c, full, c != 4);
                end
            end
            if (c == 6) begin
                total++;
                if (ovf !== 1'b1) begin
                    bad++;
                    $display("FAIL ovf_set: got %b want 1", ovf);
                end
            end
            @(posedge clk);
            #1;
        end
        wait_drain(20);
        @(negedge clk);
        total++;
        if ({ovf, full} !== 2'b10) begin
            bad++;
            $display("FAIL ovf_sticky: got ovf,full=%b want 10", {ovf, full});
        end
        @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        total++;
        if (ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear: got %b want 0", ovf);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_raster;
        do_reset();
        pix_rdy = 1'b1;
        for (int c = 0; c < 30; c++) begin
            wr = 1'b0;
            if (c < 3) put_word({$urandom, $urandom}, 1'b1);
            @(negedge clk);
            if (c == 9) begin
                total++;
                if ({eol, pix_x, pix_y} !== {1'b1, 10'd7, 10'd0}) begin
                    bad++;
                    $display("FAIL raster_eol0: got eol=%b x=%0d y=%0d want 1 7 0", eol, pix_x, pix_y);
                end
            end
            if (c == 17) begin
                total++;
                if ({eol, pix_x, pix_y, frm_end} !== {1'b1, 10'd7, 10'd1, 1'b0}) begin
                    bad++;
                    $display("FAIL raster_last: got eol=%b x=%0d y=%0d frm_end=%b want 1 7 1 0",
                             eol, pix_x, pix_y, frm_end);
                end
            end
            if (c == 18) begin
                total++;
                if ({frm_end, sof, pix_x, pix_y} !== {1'b1, 1'b1, 10'd0, 10'd0}) begin
                    bad++;
                    $display("FAIL raster_wrap: got frm_end=%b sof=%b x=%0d y=%0d want 1 1 0 0",
                             frm_end, sof, pix_x, pix_y);
                end
            end
            if (c == 19) begin
                total++;
                if (frm_end !== 1'b0) begin
                    bad++;
                    $display("FAIL raster_pulse: got frm_end=%b want 0", frm_end);
                end
            end
            @(posedge clk);
            #1;
        end
        wait_drain(20);
    endtask

    task automatic test_reset_mid;
        logic [63:0] w;
        w = 64'hD0D1D2D3D4D5D6D7;
        do_reset();
        pix_rdy = 1'b1;
        for (int c = 0; c < 5; c++) begin
            wr = 1'b0;
            if (c == 0) put_word({$urandom, $urandom}, 1'b1);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        total++;
        if ({pix_vld, pix, pix_x, pix_y, sof, eol, frm_end, full, ovf} !== 37'd0) begin
            bad++;
            $display("FAIL reset_mid_outputs: got %h want 0",
                     {pix_vld, pix, pix_x, pix_y, sof, eol, frm_end, full, ovf});
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        exp_x = 0;
        exp_y = 0;
        for (int c = 0; c < 12; c++) begin
            wr = 1'b0;
            if (c == 0) put_word(w, 1'b1);
            @(negedge clk);
            if (c == 2) begin
                total++;
                if ({pix_vld, pix, pix_x, pix_y, sof} !== {1'b1, exp_byte(w, 0), 20'd0, 1'b1}) begin
                    bad++;
                    $display("FAIL reset_mid_restart: got vld=%b pix=%h x=%0d y=%0d sof=%b want 1 %h 0 0 1",
                             pix_vld, pix, pix_x, pix_y, sof, exp_byte(w, 0));
                end
            end
            @(posedge clk);
            #1;
        end
        wait_drain(20);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        sb_total = 0;
        sb_bad   = 0;
        exp_x    = 0;
        exp_y    = 0;
        frm_pend = 1'b0;
        rst      = 1'b1;
        wr       = 1'b0;
        pix_rdy  = 1'b0;
        data     = '0;
        test_reset();
        test_latency();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_raster();
        test_reset_mid();
        @(negedge clk);
        total += sb_total;
        bad   += sb_bad;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
